regfile_mp: RTL and testbench

Multi-ported, parametrised general-purpose register file for the dual-issue core. It sits between decode/issue and the writeback stage, providing `NUM_RD` combinational read ports and `NUM_WR` synchronous write ports. A per-register pending scoreboard lets issue logic detect RAW hazards. A post-reset sweep zeroes the array so the storage itself needs no reset.

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared CPU definitions: register index/data types, register count and the
// register-file sweep FSM state encoding.
package cpuDefine;

  localparam int rfNum = 32;

  typedef logic [$clog2(rfNum)-1:0] Gr;
  typedef logic [31:0]              DType;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW hazard detection. Issue sets, write clears,
// set beats clear in the same cycle, r0 never goes pending.
module regfile_scoreboard #(
  parameter int NUM_WR   = 2,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic                clr_en   [NUM_WR],
  input  logic [ADDR_W-1:0]   clr_addr [NUM_WR],
  input  logic                set_en   [NUM_WR],
  input  logic [ADDR_W-1:0]   set_addr [NUM_WR],
  output logic [NUM_REGS-1:0] pend
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what keeps latches from being inferred.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (enable && clr_en[w]) clr_vec[clr_addr[w]] = 1'b1;
      if (enable && set_en[w]) set_vec[set_addr[w]] = 1'b1;
    end
    set_vec[0] = 1'b0;
  end

  // Clear first, then OR in sets: the newer producer keeps the bit pending.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with post-reset zeroing sweep and pending scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp
  import cpuDefine::*;
#(
  parameter int NUM_RD   = 6,
  parameter int NUM_WR   = 2,
  parameter int NUM_REGS = rfNum,
  parameter int DATA_W   = $bits(DType),
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] rd_addr  [NUM_RD],
  output logic [DATA_W-1:0] rd_data  [NUM_RD],
  output logic              rd_pend  [NUM_RD],
  input  logic              wr_en    [NUM_WR],
  input  logic [ADDR_W-1:0] wr_addr  [NUM_WR],
  input  logic [DATA_W-1:0] wr_data  [NUM_WR],
  input  logic              iss_en   [NUM_WR],
  input  logic [ADDR_W-1:0] iss_addr [NUM_WR],
  output logic              init_busy
);

  rf_state_e           state;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic                run;
  logic [NUM_REGS-1:0] pend;
  logic [DATA_W-1:0]   mem [NUM_REGS];

  assign run       = (state == RF_RUN);
  assign init_busy = (state == RF_INIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= RF_INIT;
      sweep_cnt <= ADDR_W'(1);
    end else if (state == RF_INIT) begin
      if (sweep_cnt == ADDR_W'(NUM_REGS - 1)) state <= RF_RUN;
      else                                    sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // NOTE: the array has no reset; the sweep zeroes it instead so it can map to
  // plain storage. Later ports in the loop override earlier ones on collision.
  always_ff @(posedge aclk) begin
    if (state == RF_INIT) begin
      mem[sweep_cnt] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w] != '0)) mem[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_WR  (NUM_WR),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .aclk    (aclk),
    .aresetn (aresetn),
    .enable  (run),
    .clr_en  (wr_en),
    .clr_addr(wr_addr),
    .set_en  (iss_en),
    .set_addr(iss_addr),
    .pend    (pend)
  );

  // Reads are zero while sweeping and for r0; bypass lets the highest active
  // write port override the array and hide the pending bit.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r] = '0;
      rd_pend[r] = 1'b0;
      if (run && (rd_addr[r] != '0)) begin
        rd_data[r] = mem[rd_addr[r]];
        rd_pend[r] = pend[rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w] == rd_addr[r])) begin
            rd_data[r] = wr_data[w];
            rd_pend[r] = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed hazard/collision cases, a random
// phase against a reference model, and mid-run reset.
module tb_regfile_mp;

  localparam int NUM_RD   = 6;
  localparam int NUM_WR   = 2;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ADDR_W-1:0] rd_addr  [NUM_RD];
  logic [DATA_W-1:0] rd_data  [NUM_RD];
  logic              rd_pend  [NUM_RD];
  logic              wr_en    [NUM_WR];
  logic [ADDR_W-1:0] wr_addr  [NUM_WR];
  logic [DATA_W-1:0] wr_data  [NUM_WR];
  logic              iss_en   [NUM_WR];
  logic [ADDR_W-1:0] iss_addr [NUM_WR];
  logic              init_busy;

  always #5 aclk = ~aclk;

  regfile_mp #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .init_busy(init_busy)
  );

  typedef struct {
    int          port;
    logic [31:0] d;
    logic        p;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl_mem  [NUM_REGS];
  logic        mdl_pend [NUM_REGS];
  bit          run_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [ADDR_W-1:0] a);
    logic [31:0] v;
    if (a == '0) return 32'h0;
    v = mdl_mem[a];
    if (BYP)
      for (int w = 0; w < NUM_WR; w++) if (wr_en[w] && wr_addr[w] == a) v = wr_data[w];
    return v;
  endfunction

  function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
    logic v;
    if (a == '0) return 1'b0;
    v = mdl_pend[a];
    if (BYP)
      for (int w = 0; w < NUM_WR; w++) if (wr_en[w] && wr_addr[w] == a) v = 1'b0;
    return v;
  endfunction

  task automatic idle();
    for (int w = 0; w < NUM_WR; w++) begin
      wr_en[w] = 1'b0; wr_addr[w] = '0; wr_data[w] = '0;
      iss_en[w] = 1'b0; iss_addr[w] = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      mdl_mem[i]  = 32'h0;
      mdl_pend[i] = 1'b0;
    end
  endtask

  // One clock: the model absorbs the inputs seen at the edge, then returns at negedge.
  task automatic step();
    @(posedge aclk);
    if (run_mode) begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_addr[w] != '0) begin
          mdl_mem[wr_addr[w]]  = wr_data[w];
          mdl_pend[wr_addr[w]] = 1'b0;
        end
      for (int w = 0; w < NUM_WR; w++)
        if (iss_en[w] && iss_addr[w] != '0) mdl_pend[iss_addr[w]] = 1'b1;
    end
    @(negedge aclk);
  endtask

  task automatic issue_read(input int p, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic pd);
    rd_exp_t e;
    rd_addr[p] = a;
    e.port = p; e.d = d; e.p = pd;
    sb_q.push_back(e);
  endtask

  task automatic issue_model_read(input int p, input logic [ADDR_W-1:0] a);
    issue_read(p, a, exp_data(a), exp_pend(a));
  endtask

  task automatic compare_reads(input string tag);
    rd_exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s_d%0d", tag, e.port), rd_data[e.port], e.d);
      check($sformatf("%s_p%0d", tag, e.port), {31'b0, rd_pend[e.port]}, {31'b0, e.p});
    end
  endtask

  task automatic sweep_and_count(input string tag);
    int n = 0;
    while (init_busy && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check(tag, n, NUM_REGS - 1);
    @(negedge aclk);
    model_reset();
    run_mode = 1'b1;
  endtask

  initial begin
    idle();
    for (int p = 0; p < NUM_RD; p++) rd_addr[p] = '0;
    model_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_busy", {31'b0, init_busy}, 32'h1);
    issue_read(0, 5'd5, 32'h0, 1'b0);
    compare_reads("rst_rd");

    // Port activity during the sweep must be lost.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
    iss_en[0] = 1'b1; iss_addr[0] = 5'd6;
    aresetn = 1'b1;
    sweep_and_count("sweep_len");
    idle();
    issue_read(0, 5'd4, 32'h0, 1'b0);
    issue_read(1, 5'd6, 32'h0, 1'b0);
    compare_reads("init_lost");
    issue_read(0, 5'd0, 32'h0, 1'b0);
    issue_read(1, 5'd1, 32'h0, 1'b0);
    issue_read(2, 5'd17, 32'h0, 1'b0);
    issue_read(3, 5'd30, 32'h0, 1'b0);
    issue_read(4, 5'd31, 32'h0, 1'b0);
    issue_read(5, 5'd12, 32'h0, 1'b0);
    compare_reads("empty");

    // Write r5 with same-cycle and next-cycle reads.
    @(negedge aclk);
    wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    issue_read(0, 5'd5, BYP ? 32'hDEADBEEF : 32'h0, 1'b0);
    compare_reads("r5_same");
    step(); idle();
    issue_read(0, 5'd5, 32'hDEADBEEF, 1'b0);
    compare_reads("r5_next");

    // Both ports write r7: port 1 wins.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h1111;
    wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'h2222;
    issue_read(1, 5'd7, BYP ? 32'h2222 : 32'h0, 1'b0);
    compare_reads("r7_same");
    step(); idle();
    issue_read(1, 5'd7, 32'h2222, 1'b0);
    compare_reads("r7_coll");

    // r0 ignores writes and issues.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234;
    iss_en[1] = 1'b1; iss_addr[1] = 5'd0;
    step(); idle();
    issue_read(2, 5'd0, 32'h0, 1'b0);
    compare_reads("r0");

    // Scoreboard on r9: issue at t, colliding write+issue at t+3, plain write later.
    iss_en[0] = 1'b1; iss_addr[0] = 5'd9;
    step(); idle();
    issue_read(3, 5'd9, 32'h0, 1'b1);
    compare_reads("r9_t1");
    step(); step();
    wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
    iss_en[0] = 1'b1; iss_addr[0] = 5'd9;
    issue_read(3, 5'd9, BYP ? 32'h99 : 32'h0, BYP ? 1'b0 : 1'b1);
    compare_reads("r9_t3");
    step(); idle();
    issue_read(3, 5'd9, 32'h99, 1'b1);
    compare_reads("r9_t4");
    wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'hA9;
    step(); idle();
    issue_read(3, 5'd9, 32'hA9, 1'b0);
    compare_reads("r9_clr");

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        wr_en[w]    = 1'($urandom_range(0, 1));
        wr_addr[w]  = 5'($urandom_range(0, NUM_REGS - 1));
        wr_data[w]  = $urandom;
        iss_en[w]   = 1'($urandom_range(0, 1));
        iss_addr[w] = 5'($urandom_range(0, NUM_REGS - 1));
      end
      for (int p = 0; p < NUM_RD; p++) issue_model_read(p, 5'($urandom_range(0, NUM_REGS - 1)));
      compare_reads("rand");
      step();
    end
    idle();

    // Mid-run reset after writing r3 and issuing r12.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'hAB;
    iss_en[1] = 1'b1; iss_addr[1] = 5'd12;
    step(); idle();
    issue_read(0, 5'd3, 32'hAB, 1'b0);
    issue_model_read(1, 5'd12);
    compare_reads("pre_rst");
    aresetn = 1'b0;
    run_mode = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, init_busy}, 32'h1);
    issue_read(0, 5'd3, 32'h0, 1'b0);
    issue_read(1, 5'd12, 32'h0, 1'b0);
    compare_reads("mid_rst");
    @(negedge aclk);
    aresetn = 1'b1;
    sweep_and_count("resweep_len");
    issue_read(0, 5'd3, 32'h0, 1'b0);
    issue_read(1, 5'd12, 32'h0, 1'b0);
    compare_reads("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
